// File: rtl/collision_score_pkg.sv
// collision_score_pkg: scene encodings, FSM states and block position constants shared with the block generator
package collision_score_pkg;
    localparam logic [1:0] SCN_IDLE = 2'b00;
    localparam logic [1:0] SCN_PLAY = 2'b01;
    localparam logic [1:0] SCN_OVER = 2'b10;
    localparam logic [9:0] BLK_LAND_POS = 10'd410;
    localparam logic [9:0] BLK_PARK_POS = 10'd482;
    localparam logic [9:0] BLK_IDLE_PARK = 10'd481;
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_INVUL, S_OVER} state_t;
endpackage

// File: rtl/collision_score_block_tracker.sv
// collision_score_block_tracker: per-slot hit/dodge pulse generation with a once-per-fall hit latch
module collision_score_block_tracker #(
    parameter logic [9:0] HIT_LO = 10'd350,
    parameter logic [9:0] HIT_HI = 10'd400,
    parameter logic [9:0] LAND_POS = 10'd410,
    parameter logic [9:0] PARK_POS = 10'd482
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic [9:0] pos,
    input  logic [1:0] lane,
    input  logic [1:0] player_lane,
    output logic       hit,
    output logic       dodge
);
    logic [9:0] prev_pos;
    logic       hit_flag;

    always_comb begin
        hit = pos <= LAND_POS && pos >= HIT_LO && pos <= HIT_HI && lane == player_lane && !hit_flag;
        dodge = prev_pos == LAND_POS && pos == PARK_POS && !hit_flag;
    end

    // the latch holds until the block parks so a block costs at most one life and scores nothing once hit
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            prev_pos <= '0;
            hit_flag <= 1'b0;
        end else begin
            prev_pos <= pos;
            hit_flag <= clr || pos == PARK_POS ? 1'b0 : hit_flag | hit;
        end
endmodule

// File: rtl/collision_score.sv
// collision_score: collision detection, lives/score keeping and game scene FSM
// Optional HISCORE_EN adds a hiscore output captured on entry to game over.
module collision_score
    import collision_score_pkg::*;
#(
    parameter int          NUM_BLK = 6,
    parameter logic [9:0]  HIT_LO = 10'd350,
    parameter logic [9:0]  HIT_HI = 10'd400,
    parameter logic [9:0]  LAND_POS = BLK_LAND_POS,
    parameter logic [9:0]  PARK_POS = BLK_PARK_POS,
    parameter logic [1:0]  LIVES = 2'd3,
    parameter logic [23:0] INVUL_CYC = 24'd12_500_000,
    parameter logic [13:0] SCORE_MAX = 14'd9999
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             player_lane,
    input  logic [10*NUM_BLK-1:0]  pos_blocks,
    input  logic [2*NUM_BLK-1:0]   blocks,
    output logic [1:0]             scene,
    output logic [1:0]             lives,
    output logic [13:0]            score,
    output logic                   hit_flash
`ifdef HISCORE_EN
    ,output logic [13:0]           hiscore
`endif
);
    localparam int CW = $clog2(NUM_BLK + 1);

    logic [10*NUM_BLK-1:0] pos_q;
    logic [2*NUM_BLK-1:0]  lane_q;
    logic [NUM_BLK-1:0]    hit, dodge;
    logic [CW-1:0]         dodge_cnt;
    logic [13:0]           sum, score_nxt;
    logic [23:0]           invul_cnt;
    logic                  load, live;
    state_t                state, state_nxt;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pos_q <= '0;
            lane_q <= '0;
        end else begin
            pos_q <= pos_blocks;
            lane_q <= blocks;
        end

    for (genvar i = 0; i < NUM_BLK; i++) begin : g_trk
        collision_score_block_tracker #(
            .HIT_LO(HIT_LO), .HIT_HI(HIT_HI), .LAND_POS(LAND_POS), .PARK_POS(PARK_POS)
        ) u_trk (
            .clk(clk), .rst(rst), .clr(load),
            .pos(pos_q[10*i+:10]), .lane(lane_q[2*i+:2]), .player_lane(player_lane),
            .hit(hit[i]), .dodge(dodge[i])
        );
    end

    always_comb begin
        load = start && (state == S_IDLE || state == S_OVER);
        live = state == S_PLAY || state == S_INVUL;
        dodge_cnt = '0;
        for (int j = 0; j < NUM_BLK; j++) dodge_cnt = dodge_cnt + CW'(dodge[j]);
        sum = score + 14'(dodge_cnt);
        score_nxt = load ? '0 : !live ? score : sum > SCORE_MAX ? SCORE_MAX : sum;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S_IDLE;
        else state <= state_nxt;

    // simultaneous hits collapse into one life through the OR-reduction
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_OVER: if (start) state_nxt = S_PLAY;
            S_PLAY:  if (|hit) state_nxt = lives == 2'd1 ? S_OVER : S_INVUL;
            S_INVUL: if (invul_cnt == '0) state_nxt = S_PLAY;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        scene = state == S_OVER ? SCN_OVER : live ? SCN_PLAY : SCN_IDLE;
        hit_flash = state == S_INVUL;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            lives <= '0;
            score <= '0;
            invul_cnt <= '0;
        end else begin
            score <= score_nxt;
            lives <= load ? LIVES : state == S_PLAY && |hit ? lives - 2'd1 : lives;
            invul_cnt <= state == S_PLAY ? INVUL_CYC - 24'd1 : invul_cnt - 24'(state == S_INVUL);
        end

`ifdef HISCORE_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) hiscore <= '0;
        else if (state_nxt == S_OVER && state != S_OVER && score_nxt > hiscore) hiscore <= score_nxt;
`endif
endmodule

// File: doc/collision_score.md
Name: collision_score

Overview:
- Consumer of the falling-block generator's outputs: 6 packed vertical positions `pos_blocks[59:0]` and 6 lane codes `blocks[11:0]`.
- Detects collisions with the player sprite and counts dodged blocks.
- Tracks lives and drives the 2-bit `scene` word back to the generator and the VGA/HUD logic: `scene[0]` = playing, `scene[1]` = game over.
- Runs entirely in the system `clk` domain. `clk_mov` is a divided version of `clk`, so `pos_blocks`/`blocks` are quasi-static, change at most once per `clk_mov` period, and are registered once on entry.

Parameters:
- NUM_BLK, 6, number of block slots (10-bit position and 2-bit lane each).
- HIT_LO, 10'd350, lowest position value counted as overlapping the player row.
- HIT_HI, 10'd400, highest position value counted as overlapping the player row.
- LAND_POS, 10'd410, last falling position before parking.
- PARK_POS, 10'd482, parked position.
- LIVES, 2'd3, lives loaded on game start.
- INVUL_CYC, 24'd12_500_000, clk cycles of invulnerability after a hit.
- SCORE_MAX, 14'd9999, score saturation value.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle pulse (debounced key) that starts or restarts the game
- player_lane  in  2  current lane of the player sprite
- pos_blocks  in  60  block positions, slot j at [10j+9:10j]
- blocks  in  12  block lanes, slot j at [2j+1:2j]
- scene  out  2  {game_over, playing}
- lives  out  2  remaining lives
- score  out  14  binary score, 0..9999
- hit_flash  out  1  high during invulnerability window (HUD blink)

Behaviour:
- Reset (async, rst=1): scene=2'b00, lives=0, score=0, hit_flash=0, FSM=IDLE, all tracker state cleared.
- Input stage: pos_blocks and blocks registered every clk into pos_q/lane_q. All detection uses pos_q/lane_q (1-cycle input latency).
- Per-slot tracker state: prev_pos (10b), hit_flag (1b).
  - Visible when pos_q <= LAND_POS.
  - hit_pulse = visible && HIT_LO <= pos_q <= HIT_HI && lane_q == player_lane && !hit_flag. Sets hit_flag.
  - dodge_pulse = (prev_pos == LAND_POS) && (pos_q == PARK_POS) && !hit_flag.
  - hit_flag clears when pos_q == PARK_POS.
  - prev_pos <= pos_q every clk.
- FSM states IDLE, PLAY, INVUL, OVER; scene = IDLE:00, PLAY:01, INVUL:01, OVER:10.
  - IDLE --start--> PLAY. Load lives=LIVES, score=0, clear all hit_flags.
  - PLAY --any hit_pulse--> if lives==1: lives=0, go to OVER. Else lives-1, load invul counter=INVUL_CYC-1, go to INVUL. Multiple simultaneous hits cost exactly one life.
  - INVUL: counter decrements each clk; hit_flash=1. hit_pulses still set hit_flag (no life lost, no score for that block). Counter==0 -> PLAY.
  - OVER --start--> PLAY with the same reload as from IDLE. start in PLAY/INVUL is ignored.
- Score: in PLAY/INVUL, score += popcount(dodge_pulse[5:0]) (0..6) in one cycle, 14-bit arithmetic, result clamped to SCORE_MAX. Score is frozen in IDLE/OVER.
- Same-cycle dodge and the losing hit: last life lost and a dodge of another slot in the same cycle -> the dodge still counts, then OVER.
- While scene[0]=0 the generator parks blocks at 481. Trackers must produce no pulses for 481 or for 900..1023 (not visible, not PARK_POS after LAND_POS).
- rst asserted mid-game: immediate return to reset values. No pulse generated on reset release.

Optional Feature:
- HISCORE_EN defined: adds output hiscore[13:0], reset to 0. On entry to OVER, if score > hiscore then hiscore <= score. Survives start, cleared only by rst.
- HISCORE_EN undefined: no hiscore port or register. All other behaviour identical.

Decomposition:
- Shared package/header: scene encodings (SCN_IDLE=2'b00, SCN_PLAY=2'b01, SCN_OVER=2'b10), FSM state constants, PARK_POS/LAND_POS/idle-park 481 constants shared with the block generator.
- Sub-module block_tracker: one slot's prev_pos, hit_flag and hit/dodge pulse logic. Instantiated NUM_BLK times via generate. collision_score holds the input registers, FSM, counters and popcount.

Test Plan:
- rst then start; slot0 lane=2, player_lane=1, slot0 stepped 0..410->482 -> no hit, score=1, lives=3, scene=01.
- player_lane=2, slot0 lane=2 stepped through 350..400 -> exactly one life lost (lives=2), hit_flash=1 for INVUL_CYC cycles (set to 20 in bench), that block's landing gives no score.
- Slots 0,2,5 land (410->482) on the same clk, no hits -> score increments by 3 in one cycle. Preload score to 9997 and repeat -> score=9999.
- Two slots hit in the same cycle with lives=2 -> lives=1 only. Then third hit after INVUL expires -> lives=0, scene=10. start -> lives=3, score=0, scene=01.
- rst pulsed mid-INVUL -> scene=00, lives=0, score=0, hit_flash=0 immediately (asynchronous).
- With HISCORE_EN: game ends at score 42, then a game ends at 17 -> hiscore stays 42.
